cpu_load_unit: RTL

Parametrised load path for the CPU core: accepts a load request (address plus RISC-V load funct3), issues one or two aligned word reads on the data-memory bus, merges and shifts the returned beats, and sign- or zero-extends the result to XLEN. It replaces the purely combinational extender between data memory and the register-file write port. It adds RV64 load widths, misaligned-access splitting, memory back-pressure and illegal-encoding detection.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/cpu_load_extend.sv | 34 +++
 rtl/cpu_load_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load funct3 encodings, load-unit states and the
// funct3 legality check used by the load path.
package cpu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ0,
        ST_WAIT0,
        ST_REQ1,
        ST_WAIT1,
        ST_RESP
    } load_state_e;

    // 111 is never a load; LD/LWU only exist when the datapath is 64 bits wide.
    function automatic logic load_legal(input logic [2:0] funct3, input int unsigned xlen);
        load_legal = 1'b1;
        if (funct3 == 3'b111) begin
            load_legal = 1'b0;
        end else if (xlen == 32 && (funct3 == LD || funct3 == LWU)) begin
            load_legal = 1'b0;
        end
    endfunction

endpackage

// File: rtl/cpu_load_extend.sv
// Sign/zero extension of merged load data selected by funct3; purely
// combinational.
module cpu_load_extend
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_data,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] w_word;

    // A word load only needs extending when it is narrower than the datapath.
    generate
        if (XLEN > 32) begin : g_word_ext
            assign w_word = {{(XLEN-32){~i_funct3[2] & i_data[31]}}, i_data[31:0]};
        end else begin : g_word_pass
            assign w_word = i_data;
        end
    endgenerate

    always_comb begin
        o_data = i_data;
        case (i_funct3[1:0])
            2'b00:   o_data = {{(XLEN-8){~i_funct3[2] & i_data[7]}}, i_data[7:0]};
            2'b01:   o_data = {{(XLEN-16){~i_funct3[2] & i_data[15]}}, i_data[15:0]};
            2'b10:   o_data = w_word;
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/cpu_load_unit.sv
// Load path: issues one or two aligned reads per load, merges the beats,
// shifts by the byte offset and extends the result to XLEN.
module cpu_load_unit
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic [2:0]      req_funct3,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_err,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int unsigned B    = XLEN / 8;
    localparam int unsigned OFFW = $clog2(B);
    localparam int unsigned SW   = OFFW + 2;
    localparam logic [XLEN-1:0] L_STEP = XLEN'(B);

    load_state_e r_state, w_state_next;

    logic [2:0]      r_funct3;
    logic [OFFW-1:0] r_off;
    logic            r_split;
    logic [XLEN-1:0] r_beat0, r_beat1;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_resp_data;
    logic            r_resp_err;

    logic            w_legal;
    logic [SW-1:0]   w_size;
    logic [SW-1:0]   w_end;
    logic            w_split;
    logic [XLEN-1:0] w_lo, w_hi, w_merged, w_ext;

    assign w_legal = load_legal(req_funct3, XLEN);

    always_comb begin
        w_size = '0;
        w_size[req_funct3[1:0]] = 1'b1;
    end

    assign w_end   = {2'b00, req_addr[OFFW-1:0]} + w_size;
    assign w_split = w_end > SW'(B);

    // The beat arriving this cycle is merged straight from the bus so the
    // registered result is ready in the RESP cycle; beat1 is zero until read.
    assign w_lo     = (r_state == ST_WAIT0) ? mem_rdata : r_beat0;
    assign w_hi     = (r_state == ST_WAIT1) ? mem_rdata : r_beat1;
    assign w_merged = XLEN'({w_hi, w_lo} >> {r_off, 3'b000});

    cpu_load_extend #(
        .XLEN(XLEN)
    ) u_extend (
        .i_data   (w_merged),
        .i_funct3 (r_funct3),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        resp_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = w_legal ? ST_REQ0 : ST_RESP;
                end
            end
            ST_REQ0: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) w_state_next = ST_WAIT0;
            end
            ST_WAIT0: begin
                if (mem_rsp_valid) w_state_next = r_split ? ST_REQ1 : ST_RESP;
            end
            ST_REQ1: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) w_state_next = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (mem_rsp_valid) w_state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid   = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_funct3    <= '0;
            r_off       <= '0;
            r_split     <= 1'b0;
            r_beat0     <= '0;
            r_beat1     <= '0;
            r_mem_addr  <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_funct3 <= req_funct3;
                        r_off    <= req_addr[OFFW-1:0];
                        r_split  <= w_split;
                        r_beat0  <= '0;
                        r_beat1  <= '0;
                        if (w_legal) begin
                            r_mem_addr <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                        end else begin
                            r_resp_data <= '0;
                            r_resp_err  <= 1'b1;
                        end
                    end
                end
                ST_WAIT0: begin
                    if (mem_rsp_valid) begin
                        r_beat0 <= mem_rdata;
                        if (r_split) begin
                            r_mem_addr <= r_mem_addr + L_STEP;
                        end else begin
                            r_resp_data <= w_ext;
                            r_resp_err  <= 1'b0;
                        end
                    end
                end
                ST_WAIT1: begin
                    if (mem_rsp_valid) begin
                        r_beat1     <= mem_rdata;
                        r_resp_data <= w_ext;
                        r_resp_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign resp_data = r_resp_data;
    assign resp_err  = r_resp_err;

endmodule
